// File: rtl/car_collision_resolver_if.sv
// Update bundle handed from the collision resolver to car physics on a valid/ready handshake.
interface car_collision_resolver_if #(
    parameter int VW = 16,
    parameter int AW = 10
);
    logic                 valid;
    logic                 ready;
    logic signed [VW-1:0] car1_v_x;
    logic signed [VW-1:0] car1_v_y;
    logic signed [VW-1:0] car1_v_m;
    logic signed [AW-1:0] car1_angle;
    logic signed [VW-1:0] car2_v_x;
    logic signed [VW-1:0] car2_v_y;
    logic signed [VW-1:0] car2_v_m;
    logic signed [AW-1:0] car2_angle;

    modport master (
        output valid, car1_v_x, car1_v_y, car1_v_m, car1_angle,
        output car2_v_x, car2_v_y, car2_v_m, car2_angle,
        input  ready
    );

    modport slave (
        input  valid, car1_v_x, car1_v_y, car1_v_m, car1_angle,
        input  car2_v_x, car2_v_y, car2_v_m, car2_angle,
        output ready
    );
endinterface

// File: rtl/car_collision_resolver.sv
// Turns the handler's collision flag and late-settling results into one registered update per contact.
// Optional collision counter enabled by defining CAR_COLLISION_STATS_EN.
module car_collision_resolver #(
    parameter int SETTLE_CYCLES   = 40,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int CNT_WIDTH       = 8,
    parameter int VW              = 16,
    parameter int AW              = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 frame_tick,
    input  logic                 collision,
    input  logic signed [VW-1:0] car1_v_x,
    input  logic signed [VW-1:0] car1_v_y,
    input  logic signed [VW-1:0] car1_v_m,
    input  logic signed [AW-1:0] car1_angle,
    input  logic signed [VW-1:0] car2_v_x,
    input  logic signed [VW-1:0] car2_v_y,
    input  logic signed [VW-1:0] car2_v_m,
    input  logic signed [AW-1:0] car2_angle,
    output logic                 busy,
`ifdef CAR_COLLISION_STATS_EN
    output logic [CNT_WIDTH-1:0] collision_cnt,
`endif
    car_collision_resolver_if.master upd
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, OFFER, COOLDOWN} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   settle_cnt, settle_n;
    logic [CW-1:0]   cd_cnt, cd_n;
    logic            valid_n;
    logic            latch_xy, latch_ma;
    logic            xfer;

    // Valid trails OFFER entry by one clock so the captured v_m/angle are already registered.
    always_comb begin
        state_n  = state;
        settle_n = settle_cnt;
        cd_n     = cd_cnt;
        valid_n  = upd.valid;
        latch_xy = 1'b0;
        latch_ma = 1'b0;
        xfer     = 1'b0;
        if (clear) begin
            state_n  = IDLE;
            settle_n = '0;
            cd_n     = '0;
            valid_n  = 1'b0;
        end else begin
            case (state)
                IDLE: if (collision) begin
                    latch_xy = 1'b1;
                    settle_n = SW'(SETTLE_CYCLES - 1);
                    state_n  = SETTLE;
                end
                SETTLE: if (settle_cnt == '0) begin
                    latch_ma = 1'b1;
                    state_n  = OFFER;
                end else begin
                    settle_n = settle_cnt - SW'(1);
                end
                OFFER: if (upd.valid && upd.ready) begin
                    xfer    = 1'b1;
                    valid_n = 1'b0;
                    if (COOLDOWN_FRAMES == 0) begin
                        state_n = IDLE;
                    end else begin
                        cd_n    = CW'(COOLDOWN_FRAMES);
                        state_n = COOLDOWN;
                    end
                end else begin
                    valid_n = 1'b1;
                end
                COOLDOWN: if (frame_tick) begin
                    cd_n = cd_cnt - CW'(1);
                    if (cd_cnt <= CW'(1)) begin
                        cd_n    = '0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            cd_cnt     <= '0;
            upd.valid  <= 1'b0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_n;
            cd_cnt     <= cd_n;
            upd.valid  <= valid_n;
        end
    end

    // Bundle is pure storage: bit-exact copies, held through cooldown and clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd.car1_v_x   <= '0;
            upd.car1_v_y   <= '0;
            upd.car2_v_x   <= '0;
            upd.car2_v_y   <= '0;
            upd.car1_v_m   <= '0;
            upd.car1_angle <= '0;
            upd.car2_v_m   <= '0;
            upd.car2_angle <= '0;
        end else begin
            if (latch_xy) begin
                upd.car1_v_x <= car1_v_x;
                upd.car1_v_y <= car1_v_y;
                upd.car2_v_x <= car2_v_x;
                upd.car2_v_y <= car2_v_y;
            end
            if (latch_ma) begin
                upd.car1_v_m   <= car1_v_m;
                upd.car1_angle <= car1_angle;
                upd.car2_v_m   <= car2_v_m;
                upd.car2_angle <= car2_angle;
            end
        end
    end

`ifdef CAR_COLLISION_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            collision_cnt <= '0;
        else if (clear)
            collision_cnt <= '0;
        else if (xfer && (collision_cnt != '1))
            collision_cnt <= collision_cnt + CNT_WIDTH'(1);
    end
`endif

    assign busy = (state != IDLE);

endmodule
